pwm_pulse_array: RTL and testbench

Multi-channel, parametrised successor to the single-channel pulse generator. Each of `CH_NUM` independent channels emits a burst of `N` pulses, or a continuous train, after a programmable start delay. Width, gap and idle level are set per channel. The block sits between the register/RAM configuration bank and the output pins, one channel per pin.

---
 rtl/pwm_pulse_array_if.sv | 29 ++
 rtl/pwm_pulse_array.sv | 166 ++++++++++++++++
 tb/tb_pwm_pulse_array.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_pulse_array_if.sv
// Configuration and status bundle between the config bank and the pulse array.
// The master drives enables and per-channel config; the slave returns the pin and status vectors.
interface pwm_pulse_array_if #(
    parameter int CH_NUM    = 4,
    parameter int CNT_WIDTH = 32
);
    logic [CH_NUM-1:0]           io_en;
    logic [CH_NUM-1:0]           io_defaultLevel;
    logic [CH_NUM*CNT_WIDTH-1:0] io_delayWidth;
    logic [CH_NUM*CNT_WIDTH-1:0] io_pulseWidth;
    logic [CH_NUM*CNT_WIDTH-1:0] io_unaccessWidth;
    logic [CH_NUM*CNT_WIDTH-1:0] io_pusle_times;
    logic [CH_NUM-1:0]           io_pulseOut;
    logic [CH_NUM-1:0]           pulse_valid;
    logic [CH_NUM-1:0]           pulse_busy;
    logic [CH_NUM-1:0]           pulse_done;

    modport master (
        output io_en, io_defaultLevel, io_delayWidth, io_pulseWidth,
               io_unaccessWidth, io_pusle_times,
        input  io_pulseOut, pulse_valid, pulse_busy, pulse_done
    );

    modport slave (
        input  io_en, io_defaultLevel, io_delayWidth, io_pulseWidth,
               io_unaccessWidth, io_pusle_times,
        output io_pulseOut, pulse_valid, pulse_busy, pulse_done
    );
endinterface

// File: rtl/pwm_pulse_array.sv
// CH_NUM independent burst/continuous pulse generators; all outputs registered and aligned with
// the FSM state (a start edge changes the outputs on that same clock edge); no backpressure.
module pwm_pulse_array #(
    parameter int CH_NUM    = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic             io_clk,
    input  logic             io_rst,
    pwm_pulse_array_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ACTIVE, S_GAP} state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [CNT_WIDTH-1:0] dly_in, pw_in, gw_in, times_in;
        logic                 en_in, dflt_in, start, last;
        state_t               state_q, state_d;
        logic                 en_q;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d, pcnt_q, pcnt_d;
        logic [CNT_WIDTH-1:0] pw_q, pw_d, gw_q, gw_d, times_q, times_d;
        logic                 dflt_q, dflt_d;
        logic                 out_q, out_d, valid_q, valid_d;
        logic                 busy_q, busy_d, done_q, done_d;

        assign en_in    = bus.io_en[i];
        assign dflt_in  = bus.io_defaultLevel[i];
        assign dly_in   = bus.io_delayWidth[i*CNT_WIDTH +: CNT_WIDTH];
        assign pw_in    = (bus.io_pulseWidth[i*CNT_WIDTH +: CNT_WIDTH] == '0) ? ONE
                        : bus.io_pulseWidth[i*CNT_WIDTH +: CNT_WIDTH];
        assign gw_in    = (bus.io_unaccessWidth[i*CNT_WIDTH +: CNT_WIDTH] == '0) ? ONE
                        : bus.io_unaccessWidth[i*CNT_WIDTH +: CNT_WIDTH];
        assign times_in = bus.io_pusle_times[i*CNT_WIDTH +: CNT_WIDTH];

        assign start = en_in & ~en_q;
        // Compare against times-1 so an all-ones pulse count never overflows the counter.
        assign last  = (times_q != '0) && (pcnt_q == times_q - ONE);

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pcnt_d  = pcnt_q;
            pw_d    = pw_q;
            gw_d    = gw_q;
            times_d = times_q;
            dflt_d  = dflt_q;
            out_d   = dflt_q;
            valid_d = 1'b0;
            busy_d  = 1'b1;
            done_d  = 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    out_d  = dflt_in;
                    busy_d = 1'b0;
                    cnt_d  = '0;
                    pcnt_d = '0;
                    if (start) begin
                        pw_d    = pw_in;
                        gw_d    = gw_in;
                        times_d = times_in;
                        dflt_d  = dflt_in;
                        busy_d  = 1'b1;
                        if (dly_in != '0) begin
                            state_d = S_DELAY;
                            cnt_d   = dly_in;
                        end else begin
                            state_d = S_ACTIVE;
                            cnt_d   = pw_in;
                            out_d   = ~dflt_in;
                            valid_d = 1'b1;
                        end
                    end
                end
                S_DELAY: begin
                    if (cnt_q == ONE) begin
                        state_d = S_ACTIVE;
                        cnt_d   = pw_q;
                        out_d   = ~dflt_q;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                S_ACTIVE: begin
                    out_d   = ~dflt_q;
                    valid_d = 1'b1;
                    if (cnt_q == ONE) begin
                        valid_d = 1'b0;
                        if (last) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                            pcnt_d  = '0;
                            out_d   = dflt_in;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            cnt_d   = gw_q;
                            out_d   = dflt_q;
                            if (pcnt_q != '1) pcnt_d = pcnt_q + ONE;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                S_GAP: begin
                    if (cnt_q == ONE) begin
                        state_d = S_ACTIVE;
                        cnt_d   = pw_q;
                        out_d   = ~dflt_q;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            endcase

            // Abort outranks everything, including completion of the final pulse.
            if ((state_q != S_IDLE) && !en_in) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pcnt_d  = '0;
                out_d   = dflt_in;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        end

        always_ff @(posedge io_clk or posedge io_rst) begin
            if (io_rst) begin
                state_q <= S_IDLE;
                en_q    <= 1'b0;
                cnt_q   <= '0;
                pcnt_q  <= '0;
                pw_q    <= '0;
                gw_q    <= '0;
                times_q <= '0;
                dflt_q  <= 1'b0;
                out_q   <= 1'b0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                en_q    <= en_in;
                cnt_q   <= cnt_d;
                pcnt_q  <= pcnt_d;
                pw_q    <= pw_d;
                gw_q    <= gw_d;
                times_q <= times_d;
                dflt_q  <= dflt_d;
                out_q   <= out_d;
                valid_q <= valid_d;
                busy_q  <= busy_d;
                done_q  <= done_d;
            end
        end

        assign bus.io_pulseOut[i] = out_q;
        assign bus.pulse_valid[i] = valid_q;
        assign bus.pulse_busy[i]  = busy_q;
        assign bus.pulse_done[i]  = done_q;
    end
endmodule

// File: tb/tb_pwm_pulse_array.sv
// Randomized and directed bench for pwm_pulse_array against a timeline-arithmetic reference model.
module tb_pwm_pulse_array;
    localparam int CH = 4;
    localparam int CW = 32;

    logic io_clk;
    logic io_rst;

    pwm_pulse_array_if #(.CH_NUM(CH), .CNT_WIDTH(CW)) bus ();

    pwm_pulse_array #(.CH_NUM(CH), .CNT_WIDTH(CW)) dut (
        .io_clk (io_clk),
        .io_rst (io_rst),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: per channel, latched config plus cycles elapsed since the start edge.
    bit     m_run [CH];
    bit     m_enp [CH];
    bit     m_dflt[CH];
    longint m_d[CH], m_p[CH], m_u[CH], m_n[CH], m_t[CH];
    bit     e_out[CH], e_val[CH], e_busy[CH], e_done[CH];

    initial begin
        io_clk = 1'b0;
        forever #5 io_clk = ~io_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_run[c] = 0; m_enp[c] = 0; m_t[c] = 0;
            e_out[c] = 0; e_val[c] = 0; e_busy[c] = 0; e_done[c] = 0;
        end
    endtask

    task automatic set_idle(input int c, input bit dl);
        e_out[c] = dl; e_val[c] = 0; e_busy[c] = 0; e_done[c] = 0;
    endtask

    // Expected outputs t cycles into a run, from delay/pulse/gap arithmetic.
    task automatic eval(input int c, input bit dl);
        longint tp, len, r;
        e_done[c] = 0;
        if (m_t[c] < m_d[c]) begin
            e_out[c] = m_dflt[c]; e_val[c] = 0; e_busy[c] = 1;
        end else begin
            tp  = m_t[c] - m_d[c];
            len = m_n[c] * m_p[c] + (m_n[c] - 1) * m_u[c];
            if (m_n[c] != 0 && tp >= len) begin
                set_idle(c, dl);
                e_done[c] = 1;
                m_run[c]  = 0;
            end else begin
                r = tp % (m_p[c] + m_u[c]);
                e_val[c]  = (r < m_p[c]);
                e_out[c]  = (r < m_p[c]) ? ~m_dflt[c] : m_dflt[c];
                e_busy[c] = 1;
            end
        end
    endtask

    task automatic model_edge();
        bit en, dl;
        for (int c = 0; c < CH; c++) begin
            en = bus.io_en[c];
            dl = bus.io_defaultLevel[c];
            if (m_run[c] && !en) begin
                m_run[c] = 0;
                set_idle(c, dl);
            end else if (m_run[c]) begin
                m_t[c]++;
                eval(c, dl);
            end else if (en && !m_enp[c]) begin
                m_d[c]    = longint'(bus.io_delayWidth[c*CW +: CW]);
                m_p[c]    = longint'(bus.io_pulseWidth[c*CW +: CW]);
                m_u[c]    = longint'(bus.io_unaccessWidth[c*CW +: CW]);
                m_n[c]    = longint'(bus.io_pusle_times[c*CW +: CW]);
                if (m_p[c] == 0) m_p[c] = 1;
                if (m_u[c] == 0) m_u[c] = 1;
                m_dflt[c] = dl;
                m_run[c]  = 1;
                m_t[c]    = 0;
                eval(c, dl);
            end else begin
                set_idle(c, dl);
            end
            m_enp[c] = en;
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("out%0d", c),   64'(bus.io_pulseOut[c]), 64'(e_out[c]));
            chk($sformatf("valid%0d", c), 64'(bus.pulse_valid[c]), 64'(e_val[c]));
            chk($sformatf("busy%0d", c),  64'(bus.pulse_busy[c]),  64'(e_busy[c]));
            chk($sformatf("done%0d", c),  64'(bus.pulse_done[c]),  64'(e_done[c]));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge io_clk);
        #1;
        compare_all();
    endtask

    task automatic set_cfg(input int c, input int d, input int p, input int u, input int n, input bit dl);
        bus.io_delayWidth[c*CW +: CW]    = d;
        bus.io_pulseWidth[c*CW +: CW]    = p;
        bus.io_unaccessWidth[c*CW +: CW] = u;
        bus.io_pusle_times[c*CW +: CW]   = n;
        bus.io_defaultLevel[c]           = dl;
    endtask

    task automatic run_idle(input int budget);
        int k = 0;
        bit any;
        any = 1;
        while (any && k < budget) begin
            tick();
            k++;
            any = (bus.pulse_busy != '0);
            for (int c = 0; c < CH; c++) if (m_run[c]) any = 1;
        end
        if (any) chk("idle_timeout", 64'(bus.pulse_busy), 64'd0);
    endtask

    initial begin
        int busy_cnt, done_at, done_cnt;

        io_rst = 1'b1;
        bus.io_en = '0;
        bus.io_defaultLevel = '0;
        bus.io_delayWidth = '0;
        bus.io_pulseWidth = '0;
        bus.io_unaccessWidth = '0;
        bus.io_pusle_times = '0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge io_clk);
        #1;
        io_rst = 1'b0;
        tick();

        // Single finite burst on ch0
        set_cfg(0, 0, 25, 15, 10, 0);
        bus.io_en[0] = 1'b1;
        busy_cnt = 0; done_at = 0;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (bus.pulse_busy[0]) busy_cnt++;
            if (bus.pulse_done[0]) done_at = i;
        end
        chk("t1_busy_cycles", 64'(busy_cnt), 64'd385);
        chk("t1_done_cycle", 64'(done_at), 64'd386);
        bus.io_en[0] = 1'b0;
        tick();

        // Delay with inverted idle level on ch1
        set_cfg(1, 7, 3, 4, 2, 1);
        tick();
        bus.io_en[1] = 1'b1;
        done_at = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (bus.pulse_done[1]) done_at = i;
        end
        chk("t2_done_cycle", 64'(done_at), 64'd18);
        chk("t2_out_idle", 64'(bus.io_pulseOut[1]), 64'd1);
        bus.io_en[1] = 1'b0;
        tick();

        // Continuous square wave on ch2 then abort
        set_cfg(2, 0, 2, 2, 0, 0);
        bus.io_en[2] = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.pulse_done[2]) done_cnt++;
        end
        bus.io_en[2] = 1'b0;
        tick();
        if (bus.pulse_done[2]) done_cnt++;
        chk("t3_done_count", 64'(done_cnt), 64'd0);
        chk("t3_busy_after_abort", 64'(bus.pulse_busy[2]), 64'd0);
        chk("t3_out_after_abort", 64'(bus.io_pulseOut[2]), 64'd0);

        // Zero width pulse/gap clamp to one cycle on ch3
        set_cfg(3, 0, 0, 0, 3, 0);
        bus.io_en[3] = 1'b1;
        done_at = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.pulse_done[3]) done_at = i;
        end
        chk("t5_zero_width_done", 64'(done_at), 64'd6);
        bus.io_en[3] = 1'b0;
        tick();

        // Concurrent randomized channels with mid-run config churn, aborts and restarts
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < CH; c++)
                set_cfg(c, $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 4),
                        $urandom_range(0, 6), 1'($urandom_range(0, 1)));
            tick();
            bus.io_en = '1;
            for (int k = 0; k < 300; k++) begin
                tick();
                for (int c = 0; c < CH; c++) begin
                    if ($urandom_range(0, 3) == 0)
                        set_cfg(c, $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 4),
                                $urandom_range(0, 6), 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 59) == 0) bus.io_en[c] = ~bus.io_en[c];
                end
            end
            bus.io_en = '0;
            run_idle(50);
        end

        // Reset mid-burst, enable held high through reset release
        for (int c = 0; c < CH; c++) set_cfg(c, 2, 5, 3, 20, 1'(c & 1));
        tick();
        bus.io_en = '1;
        repeat (10) tick();
        #2;
        io_rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge io_clk);
        #1;
        compare_all();
        io_rst = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        bus.io_en = '0;
        run_idle(50);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
